// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for truth_table_sequencer: state encoding and vector-count helper.
package tt_seq_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] tt_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_APPLY   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic int num_vec(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter: loaded while a vector is applied, expires on the last settle cycle.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    generate
        if (SETTLE == 0) begin : g_passthru
            logic unused_s;
            assign unused_s = ^{clk, rst, load};
            assign expired  = 1'b1;
        end else begin : g_counter
            localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
            localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

            logic [CNT_W-1:0] cnt_r;

            // Count remaining settle cycles; zero means the current cycle is the last one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r <= '0;
                end else if (load) begin
                    cnt_r <= LOAD_VAL;
                end else if (cnt_r != '0) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end
            end

            assign expired = (cnt_r == '0);
        end
    endgenerate

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector of a combinational block and checks it against a golden column.
// Optional TTSEQ_CAPTURE_EN adds the 'captured' port holding the observed truth table.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [(1<<N_IN)-1:0]    expected,
    output logic [N_IN-1:0]         vec_out,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           fail_count,
    output logic [N_IN-1:0]         first_fail,
    output logic                    first_fail_vld
`ifdef TTSEQ_CAPTURE_EN
    ,
    output logic [(1<<N_IN)-1:0]    captured
`endif
);

    localparam int NUM_VEC = num_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   FAIL_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]   FAIL_MAX  = {1'b1, {N_IN{1'b0}}};
    localparam logic [2:0]      AFTER_APPLY = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    tt_state_t               state_r;
    tt_state_t               next_s;
    logic [NUM_VEC-1:0]      exp_q_r;
    logic [N_IN-1:0]         vec_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    pass_r;
    logic [N_IN:0]           fail_cnt_r;
    logic [N_IN-1:0]         first_fail_r;
    logic                    first_fail_vld_r;
    logic                    accept_s;
    logic                    mismatch_s;
    logic                    expired_s;
    logic                    load_s;

    assign accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign mismatch_s = dut_out ^ exp_q_r[vec_r];
    assign load_s     = (state_r == ST_APPLY);

    tt_settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .expired (expired_s)
    );

    // Next-state decode for the vector walk.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:    if (start) next_s = ST_APPLY; else next_s = ST_IDLE;
            ST_APPLY:   next_s = AFTER_APPLY;
            ST_SETTLE:  if (expired_s) next_s = ST_CAPTURE; else next_s = ST_SETTLE;
            ST_CAPTURE: if (vec_r == LAST_VEC) next_s = ST_DONE; else next_s = ST_APPLY;
            ST_DONE:    if (start) next_s = ST_APPLY; else next_s = ST_IDLE;
            default:    next_s = ST_IDLE;
        endcase
    end

    // State, stimulus vector and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            exp_q_r          <= '0;
            vec_r            <= '0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            fail_cnt_r       <= '0;
            first_fail_r     <= '0;
            first_fail_vld_r <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s == ST_APPLY) || (next_s == ST_SETTLE) || (next_s == ST_CAPTURE);
            done_r  <= (state_r == ST_DONE);
            if (accept_s) begin
                exp_q_r          <= expected;
                vec_r            <= '0;
                pass_r           <= 1'b0;
                fail_cnt_r       <= '0;
                first_fail_vld_r <= 1'b0;
            end else if (state_r == ST_CAPTURE) begin
                if (vec_r != LAST_VEC) begin
                    vec_r <= vec_r + VEC_ONE;
                end
                if (mismatch_s) begin
                    if (fail_cnt_r != FAIL_MAX) begin
                        fail_cnt_r <= fail_cnt_r + FAIL_ONE;
                    end
                    if (!first_fail_vld_r) begin
                        first_fail_r     <= vec_r;
                        first_fail_vld_r <= 1'b1;
                    end
                end
            end
            // pass must coincide with the done pulse, even when a back-to-back start is taken.
            if (state_r == ST_DONE) begin
                pass_r <= (fail_cnt_r == '0);
            end
        end
    end

`ifdef TTSEQ_CAPTURE_EN
    logic [NUM_VEC-1:0] captured_r;

    // Observed truth table, one bit per vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured_r <= '0;
        end else if (accept_s) begin
            captured_r <= '0;
        end else if (state_r == ST_CAPTURE) begin
            captured_r[vec_r] <= dut_out;
        end
    end

    assign captured = captured_r;
`endif

    assign vec_out        = vec_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign fail_count     = fail_cnt_r;
    assign first_fail     = first_fail_r;
    assign first_fail_vld = first_fail_vld_r;

endmodule
